// File: rtl/raw10_unpacker.sv
// raw10_unpacker: CSI-2 RAW10 byte stream (2 bytes/clk) to 4-pixel words.
// Define RAW10_MSB_ALIGN_EN for left-justified pixels; default is zero-extended.
module raw10_unpacker (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        frame_active,
  input  logic        frame_valid,
  output logic [63:0] dout,
  output logic        valid
);

  typedef enum logic [2:0] {
    PH0, PH1, PH2, PH3, PH4
  } phase_t;

  phase_t      r_phase;
  phase_t      w_phase_nxt;
  logic [7:0]  r_m0, r_m1, r_m2, r_m3;
  logic [7:0]  w_lo, w_hi;
  logic        w_take;
  logic        w_emit;
  logic [63:0] w_grp;

  assign w_lo   = din[7:0];
  assign w_hi   = din[15:8];
  assign w_take = frame_active & frame_valid;

  function automatic logic [15:0] f_pix(
    input logic [7:0] msb,
    input logic [1:0] lsb
  );
`ifdef RAW10_MSB_ALIGN_EN
    return {msb, lsb, 6'b0};
`else
    return {6'b0, msb, lsb};
`endif
  endfunction

  // Phase register; packet gaps and reset return to the first beat.
  always_ff @(posedge clk) begin
    if (reset) r_phase <= PH0;
    else       r_phase <= w_phase_nxt;
  end

  // Next phase and the group assembled on an LSB-carrying beat.
  always_comb begin
    w_phase_nxt = r_phase;
    w_emit      = 1'b0;
    w_grp       = '0;
    if (!frame_active) begin
      w_phase_nxt = PH0;
    end else if (frame_valid) begin
      unique case (r_phase)
        PH0: w_phase_nxt = PH1;
        PH1: w_phase_nxt = PH2;
        PH2: begin
          w_phase_nxt = PH3;
          w_emit      = 1'b1;
          w_grp       = {f_pix(r_m3, w_lo[7:6]),
                         f_pix(r_m2, w_lo[5:4]),
                         f_pix(r_m1, w_lo[3:2]),
                         f_pix(r_m0, w_lo[1:0])};
        end
        PH3: w_phase_nxt = PH4;
        PH4: begin
          w_phase_nxt = PH0;
          w_emit      = 1'b1;
          w_grp       = {f_pix(w_lo, w_hi[7:6]),
                         f_pix(r_m2, w_hi[5:4]),
                         f_pix(r_m1, w_hi[3:2]),
                         f_pix(r_m0, w_hi[1:0])};
        end
        default: w_phase_nxt = PH0;
      endcase
    end
  end

  // Byte holding registers; slot 0 is reused for B0 while group A emits.
  always_ff @(posedge clk) begin
    if (reset || !frame_active) begin
      r_m0 <= '0;
      r_m1 <= '0;
      r_m2 <= '0;
      r_m3 <= '0;
    end else if (w_take) begin
      unique case (r_phase)
        PH0: begin
          r_m0 <= w_lo;
          r_m1 <= w_hi;
        end
        PH1: begin
          r_m2 <= w_lo;
          r_m3 <= w_hi;
        end
        PH2: r_m0 <= w_hi;
        PH3: begin
          r_m1 <= w_lo;
          r_m2 <= w_hi;
        end
        default: ;
      endcase
    end
  end

  // Registered output word and one-cycle valid pulse; dout holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= w_emit;
      if (w_emit) dout <= w_grp;
    end
  end

endmodule

// File: tb/tb_raw10_unpacker.sv
// tb_raw10_unpacker: directed vectors against a byte-queue RAW10 model.
// Honours RAW10_MSB_ALIGN_EN the same way as the design.
module tb_raw10_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = '0;
  logic        frame_active = 1'b0;
  logic        frame_valid = 1'b0;
  logic [63:0] dout;
  logic        valid;

  int n_vec = 0;
  int n_bad = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  logic [7:0]  q[$];
  logic        exp_valid = 1'b0;
  logic [63:0] exp_dout = '0;

  localparam logic [63:0] BASIC = 64'h0013_000E_0009_0004;
  localparam logic [63:0] ALLFF = 64'h03FF_03FF_03FF_03FF;
  localparam logic [63:0] MIXA  = 64'h0100_00C1_0082_0043;
  localparam logic [63:0] MIXB  = 64'h0203_01C2_0181_0140;

  raw10_unpacker dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .frame_active(frame_active),
    .frame_valid(frame_valid),
    .dout(dout),
    .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix(
    input logic [7:0] m,
    input logic [1:0] l
  );
    logic [15:0] v;
    v = {6'b0, m, l};
`ifdef RAW10_MSB_ALIGN_EN
    v = v << 6;
`endif
    return v;
  endfunction

  function automatic logic [63:0] cfg(input logic [63:0] z);
    logic [63:0] r;
    r = z;
`ifdef RAW10_MSB_ALIGN_EN
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = z[i*16 +: 16] << 6;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic step(input logic r, input logic a, input logic v,
                      input logic [15:0] d);
    logic [7:0] b[5];
    @(negedge clk);
    reset = r;
    frame_active = a;
    frame_valid = v;
    din = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_valid = 1'b0;
      exp_dout = '0;
    end else if (!a) begin
      q.delete();
      exp_valid = 1'b0;
    end else if (v) begin
      q.push_back(d[7:0]);
      q.push_back(d[15:8]);
      if (q.size() >= 5) begin
        for (int i = 0; i < 5; i++) b[i] = q.pop_front();
        exp_dout = {pix(b[3], b[4][7:6]), pix(b[2], b[4][5:4]),
                    pix(b[1], b[4][3:2]), pix(b[0], b[4][1:0])};
        exp_valid = 1'b1;
        pulses++;
      end else begin
        exp_valid = 1'b0;
      end
    end else begin
      exp_valid = 1'b0;
    end
    chk_en = 1'b1;
  endtask

  task automatic basic_group();
    step(0, 1, 1, 16'h0201);
    step(0, 1, 1, 16'h0403);
    step(0, 1, 1, 16'h55E4);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (valid !== exp_valid || dout !== exp_dout) begin
        n_bad++;
        $display("FAIL cycle t=%0t: valid=%b dout=%h, required valid=%b dout=%h",
                 $time, valid, dout, exp_valid, exp_dout);
      end
    end
  end

  initial begin
    step(1, 0, 0, 16'h0);
    step(1, 1, 1, 16'hFFFF);
    #1;
    chk("reset_dout", dout, 64'h0);
    chk("reset_valid", {63'b0, valid}, 64'h0);
    step(0, 0, 0, 16'h0);

    pulses = 0;
    basic_group();
    #1;
    chk("basic_model", exp_dout, cfg(BASIC));
    chk("basic_dout", dout, cfg(BASIC));
    chk("basic_valid", {63'b0, valid}, 64'h1);
    step(0, 0, 0, 16'h0);
    chk("basic_pulses", 64'(pulses), 64'd1);

    pulses = 0;
    for (int i = 0; i < 5; i++) step(0, 1, 1, 16'hFFFF);
    #1;
    chk("ff_dout", dout, cfg(ALLFF));
    step(0, 0, 0, 16'h0);
    chk("ff_pulses", 64'(pulses), 64'd2);

    pulses = 0;
    step(0, 1, 1, 16'h0201);
    step(0, 1, 1, 16'h0403);
    step(0, 1, 0, 16'hDEAD);
    step(0, 1, 0, 16'hBEEF);
    #1;
    chk("stall_novalid", {63'b0, valid}, 64'h0);
    step(0, 1, 1, 16'h55E4);
    #1;
    chk("stall_dout", dout, cfg(BASIC));
    step(0, 0, 0, 16'h0);
    chk("stall_pulses", 64'(pulses), 64'd1);

    pulses = 0;
    step(0, 1, 1, 16'hA5A5);
    step(0, 1, 1, 16'h5A5A);
    step(0, 0, 1, 16'h1234);
    basic_group();
    #1;
    chk("abort_dout", dout, cfg(BASIC));
    step(0, 0, 0, 16'h0);
    chk("abort_pulses", 64'(pulses), 64'd1);

    pulses = 0;
    step(0, 1, 1, 16'h2010);
    step(0, 1, 1, 16'h4030);
    step(0, 1, 1, 16'h501B);
    #1;
    chk("mixA_model", exp_dout, cfg(MIXA));
    chk("mixA_dout", dout, cfg(MIXA));
    step(0, 1, 1, 16'h7060);
    step(0, 1, 1, 16'hE480);
    #1;
    chk("mixB_model", exp_dout, cfg(MIXB));
    chk("mixB_dout", dout, cfg(MIXB));
    step(0, 1, 1, 16'h9999);
    step(0, 1, 1, 16'h7777);
    step(0, 1, 1, 16'h3333);
    step(0, 0, 0, 16'h0);
    chk("partial_tail_pulses", 64'(pulses), 64'd3);

    pulses = 0;
    step(0, 1, 1, 16'h0201);
    step(0, 1, 1, 16'h0403);
    step(1, 1, 1, 16'hFFFF);
    #1;
    chk("midrst_dout", dout, 64'h0);
    chk("midrst_valid", {63'b0, valid}, 64'h0);
    basic_group();
    #1;
    chk("midrst_after_dout", dout, cfg(BASIC));
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    chk("midrst_pulses", 64'(pulses), 64'd1);
    chk("hold_dout", dout, cfg(BASIC));

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
